// File: rtl/arm_mc_alu.sv
// -----------------------------------------------------------------------------
// arm_mc_alu
//   Multi-cycle ALU between the decode/controller stage and the writeback mux.
//   It accepts one operation per valid/ready handshake and presents a registered
//   result plus a registered NZCV flag word. ADD/SUB/AND/ORR/EOR finish on the
//   accept edge. MUL/MULH go through an iterative shift-add multiplier that
//   consumes one multiplier bit per cycle.
//
// Ports
//   i_clk        rising-edge clock
//   i_rst_n      asynchronous reset, active low
//   i_in_valid   operation presented on i_op/i_src_a/i_src_b/i_set_flags
//   o_in_ready   ALU can accept (transfer when i_in_valid && o_in_ready)
//   i_op         000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 MUL,
//                110 MULH, 111 reserved
//   i_src_a      operand A
//   i_src_b      operand B
//   i_set_flags  load NZCV when this operation's result is produced
//   o_out_valid  result valid, held until o_out_valid && i_out_ready
//   i_out_ready  consumer accepts the result
//   o_result     registered result
//   o_flags      registered {N,Z,C,V}
// -----------------------------------------------------------------------------
module arm_mc_alu #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_src_a,
    input  logic [WIDTH-1:0] i_src_b,
    input  logic             i_set_flags,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_result,
    output logic [3:0]       o_flags
);

    localparam int CW  = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_ORR  = 3'b011;
    localparam logic [2:0] OP_EOR  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_MULH = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MULT = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_result;
    logic [3:0]         r_flags;
    logic [WIDTH-1:0]   r_mcand;      // multiplicand captured at accept
    logic [2*WIDTH-1:0] r_prod;       // {partial product, remaining multiplier bits}
    logic [CW-1:0]      r_cnt;
    logic               r_mulh;
    logic               r_set_flags;

    logic               w_accept;
    logic               w_is_mul;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_sub;
    logic [WIDTH-1:0]   w_alu_res;
    logic               w_alu_c;
    logic               w_alu_v;
    logic               w_alu_flag_en;
    logic [WIDTH:0]     w_step_sum;
    logic [2*WIDTH-1:0] w_prod_next;
    logic               w_mul_last;
    logic [WIDTH-1:0]   w_mul_res;

    assign o_in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && i_out_ready);
    assign o_out_valid = (r_state == S_DONE);
    assign o_result    = r_result;
    assign o_flags     = r_flags;

    assign w_accept = i_in_valid && o_in_ready;
    // With the multiplier left out, MUL/MULH fall through to the reserved path.
    assign w_is_mul = MUL_EN && ((i_op == OP_MUL) || (i_op == OP_MULH));

    // The extra top bit is the carry for ADD and the borrow for SUB.
    assign w_add = {1'b0, i_src_a} + {1'b0, i_src_b};
    assign w_sub = {1'b0, i_src_a} - {1'b0, i_src_b};

    always_comb begin
        w_alu_res     = '0;
        w_alu_c       = r_flags[1];
        w_alu_v       = r_flags[0];
        w_alu_flag_en = 1'b0;
        case (i_op)
            OP_ADD: begin
                w_alu_res     = w_add[WIDTH-1:0];
                w_alu_c       = w_add[WIDTH];
                w_alu_v       = (i_src_a[MSB] == i_src_b[MSB]) && (w_add[MSB] != i_src_a[MSB]);
                w_alu_flag_en = 1'b1;
            end
            OP_SUB: begin
                w_alu_res     = w_sub[WIDTH-1:0];
                w_alu_c       = ~w_sub[WIDTH];
                w_alu_v       = (i_src_a[MSB] != i_src_b[MSB]) && (w_sub[MSB] != i_src_a[MSB]);
                w_alu_flag_en = 1'b1;
            end
            OP_AND: begin
                w_alu_res     = i_src_a & i_src_b;
                w_alu_flag_en = 1'b1;
            end
            OP_ORR: begin
                w_alu_res     = i_src_a | i_src_b;
                w_alu_flag_en = 1'b1;
            end
            OP_EOR: begin
                w_alu_res     = i_src_a ^ i_src_b;
                w_alu_flag_en = 1'b1;
            end
            default: begin
                // Reserved (and MUL/MULH without a multiplier): zero result,
                // flags never touched.
                w_alu_res     = '0;
                w_alu_flag_en = 1'b0;
            end
        endcase
    end

    // One shift-add step: conditionally add the multiplicand into the upper
    // half, then shift the whole product right. The multiplier bits drain out
    // of the bottom as product bits fill in from the top.
    assign w_step_sum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} +
                         (r_prod[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    assign w_prod_next = {w_step_sum, r_prod[WIDTH-1:1]};
    assign w_mul_last  = (r_cnt == CW'(WIDTH - 1));
    assign w_mul_res   = r_mulh ? w_prod_next[2*WIDTH-1:WIDTH] : w_prod_next[WIDTH-1:0];

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_in_valid) begin
                    w_state_next = w_is_mul ? S_MULT : S_DONE;
                end
            end
            S_MULT: begin
                if (w_mul_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                // A new op accepted here retires the old result on the same edge.
                if (i_out_ready) begin
                    if (i_in_valid) begin
                        w_state_next = w_is_mul ? S_MULT : S_DONE;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_result    <= '0;
            r_flags     <= 4'b0000;
            r_mcand     <= '0;
            r_prod      <= '0;
            r_cnt       <= '0;
            r_mulh      <= 1'b0;
            r_set_flags <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_mcand     <= i_src_a;
                r_prod      <= {{WIDTH{1'b0}}, i_src_b};
                r_cnt       <= '0;
                r_mulh      <= (i_op == OP_MULH);
                r_set_flags <= i_set_flags;
                if (!w_is_mul) begin
                    r_result <= w_alu_res;
                    if (i_set_flags && w_alu_flag_en) begin
                        r_flags <= {w_alu_res[MSB], (w_alu_res == '0), w_alu_c, w_alu_v};
                    end
                end
            end else if (r_state == S_MULT) begin
                r_prod <= w_prod_next;
                r_cnt  <= r_cnt + 1'b1;
                if (w_mul_last) begin
                    r_result <= w_mul_res;
                    // Multiplies only touch N and Z; C and V carry over.
                    if (r_set_flags) begin
                        r_flags <= {w_mul_res[MSB], (w_mul_res == '0), r_flags[1:0]};
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_arm_mc_alu.sv
// -----------------------------------------------------------------------------
// tb_arm_mc_alu
//   Bench for arm_mc_alu (WIDTH=32). A transaction-level reference model
//   predicts out_valid/in_ready/result/flags each cycle from plain arithmetic
//   and a countdown for multiply latency. Directed cases with literal answers
//   pin the model; a randomized phase exercises handshakes and back-pressure.
//   A second instance built without the multiplier covers the reserved path.
// -----------------------------------------------------------------------------
module tb_arm_mc_alu;

    localparam int W = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        set_flags;
    logic        out_ready;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] result;
    logic [3:0]  flags;

    logic        d2_in_valid;
    logic [2:0]  d2_op;
    logic [31:0] d2_src_a;
    logic [31:0] d2_src_b;
    logic        d2_set_flags;
    logic        d2_out_ready;
    logic        d2_in_ready;
    logic        d2_out_valid;
    logic [31:0] d2_result;
    logic [3:0]  d2_flags;

    int n_pass  = 0;
    int n_total = 0;
    int or_mode = 1;   // 0: random out_ready, 1: always 1, 2: always 0

    always #5 clk = ~clk;

    arm_mc_alu #(.WIDTH(W), .MUL_EN(1'b1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_op(op), .i_src_a(src_a), .i_src_b(src_b), .i_set_flags(set_flags),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_result(result), .o_flags(flags)
    );

    arm_mc_alu #(.WIDTH(W), .MUL_EN(1'b0)) dut_nomul (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(d2_in_valid), .o_in_ready(d2_in_ready),
        .i_op(d2_op), .i_src_a(d2_src_a), .i_src_b(d2_src_b), .i_set_flags(d2_set_flags),
        .o_out_valid(d2_out_valid), .i_out_ready(d2_out_ready), .o_result(d2_result),
        .o_flags(d2_flags)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_valid;
    int          m_busy;      // cycles left before a multiply result appears
    logic [31:0] m_res;
    logic [3:0]  m_flags;
    logic [31:0] m_p_res;
    logic        m_p_upd;

    function automatic void alu_model(input logic [2:0] f_op, input logic [31:0] a,
                                      input logic [31:0] b, input logic [1:0] cur_cv,
                                      input bit mul_en, output logic [31:0] res,
                                      output logic upd, output logic [1:0] cv,
                                      output logic is_mul);
        longint          sa;
        longint          sb;
        longint          s;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        cv = cur_cv;
        upd = 1'b1;
        is_mul = 1'b0;
        res = 32'h0;
        case (f_op)
            3'd0: begin
                p = ua + ub;
                res = p[31:0];
                s = sa + sb;
                cv = {p > 64'hFFFF_FFFF, (s > SMAX) || (s < SMIN)};
            end
            3'd1: begin
                res = a - b;
                s = sa - sb;
                cv = {a >= b, (s > SMAX) || (s < SMIN)};
            end
            3'd2: res = a & b;
            3'd3: res = a | b;
            3'd4: res = a ^ b;
            3'd5, 3'd6: begin
                if (mul_en) begin
                    p = ua * ub;
                    res = (f_op == 3'd5) ? p[31:0] : p[63:32];
                    is_mul = 1'b1;
                end else begin
                    upd = 1'b0;
                end
            end
            default: upd = 1'b0;
        endcase
    endfunction

    task automatic model_load(input logic [31:0] res, input logic upd, input logic [1:0] cv);
        m_res = res;
        m_valid = 1'b1;
        if (upd) m_flags = {res[31], res == 32'h0, cv};
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_busy  = 0;
        m_res   = 32'h0;
        m_flags = 4'b0000;
        m_p_res = 32'h0;
        m_p_upd = 1'b0;
    endtask

    task automatic model_step();
        bit          rdy;
        bit          acc;
        logic [31:0] r;
        logic        u;
        logic [1:0]  cv;
        logic        mul;
        if (!rst_n) begin
            model_reset();
        end else begin
            rdy = (m_busy == 0 && !m_valid) || (m_valid && out_ready);
            acc = in_valid && rdy;
            if (m_valid && out_ready) m_valid = 1'b0;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) model_load(m_p_res, m_p_upd, m_flags[1:0]);
            end
            if (acc) begin
                alu_model(op, src_a, src_b, m_flags[1:0], 1'b1, r, u, cv, mul);
                if (mul) begin
                    m_busy  = W;
                    m_p_res = r;
                    m_p_upd = set_flags && u;
                end else begin
                    model_load(r, set_flags && u, cv);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Compare DUT against model every cycle, away from the edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            check("out_valid", {63'b0, out_valid}, {63'b0, m_valid});
            check("in_ready", {63'b0, in_ready},
                  {63'b0, (m_busy == 0 && !m_valid) || (m_valid && out_ready)});
            check("result", {32'b0, result}, {32'b0, m_res});
            check("flags", {60'b0, flags}, {60'b0, m_flags});
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            case (or_mode)
                0:       out_ready = 1'($urandom_range(0, 1));
                2:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    // ---------------- driver helpers ----------------
    task automatic scramble();
        src_a = $urandom;
        src_b = $urandom;
        op    = 3'($urandom_range(0, 7));
        set_flags = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #2;
            if (in_ready && !out_valid) break;
        end
        check("idle_reached", {62'b0, in_ready, out_valid}, 64'd2);
    endtask

    task automatic send_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                           input logic sf);
        int guard;
        @(negedge clk);
        op = o; src_a = a; src_b = b; set_flags = sf; in_valid = 1'b1;
        #1;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check("accept_in_time", {63'b0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        scramble();
    endtask

    task automatic run_directed(input string name, input logic [2:0] o, input logic [31:0] a,
                                input logic [31:0] b, input logic sf, input logic [31:0] er,
                                input logic [3:0] ef, input int elat);
        int lat;
        int ready_seen;
        or_mode = 1;
        wait_idle();
        @(negedge clk);
        op = o; src_a = a; src_b = b; set_flags = sf; in_valid = 1'b1;
        #1;
        check({name, "_ready"}, {63'b0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        scramble();
        #1;
        lat = 1;
        ready_seen = 0;
        while (!out_valid && lat < 80) begin
            if (in_ready) ready_seen++;
            @(posedge clk);
            #2;
            lat++;
        end
        check({name, "_latency"}, 64'(lat), 64'(elat));
        check({name, "_result"}, {32'b0, result}, {32'b0, er});
        check({name, "_flags"}, {60'b0, flags}, {60'b0, ef});
        if (elat > 1) check({name, "_busy_ready"}, 64'(ready_seen), 64'd0);
        $display("directed %s: op=%0d a=%h b=%h -> result=%h flags=%b lat=%0d",
                 name, o, a, b, result, flags, lat);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int cnt;
        logic [31:0] ra;
        logic [31:0] rb;
        rst_n = 1'b0; in_valid = 1'b0; op = 3'd0; src_a = 32'h0; src_b = 32'h0;
        set_flags = 1'b0; out_ready = 1'b1;
        d2_in_valid = 1'b0; d2_op = 3'd0; d2_src_a = 32'h0; d2_src_b = 32'h0;
        d2_set_flags = 1'b0; d2_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_result", {32'b0, result}, 64'd0);
        check("reset_flags", {60'b0, flags}, 64'd0);
        check("reset_out_valid", {63'b0, out_valid}, 64'd0);
        check("reset_in_ready", {63'b0, in_ready}, 64'd1);
        rst_n = 1'b1;

        run_directed("T1_add", 3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0, 4'b0110, 1);
        run_directed("T2_sub", 3'd1, 32'h5, 32'h7, 1'b1, 32'hFFFF_FFFE, 4'b1000, 1);
        run_directed("T2_addv", 3'd0, 32'h7FFF_FFFF, 32'h1, 1'b1, 32'h8000_0000, 4'b1001, 1);
        run_directed("T3_mul", 3'd5, 32'h0001_0000, 32'h0001_0000, 1'b0, 32'h0, 4'b1001, 33);
        run_directed("T3_mulh", 3'd6, 32'h0001_0000, 32'h0001_0000, 1'b1, 32'h1, 4'b0001, 33);

        // T4: back-pressure hold then same-edge handoff.
        or_mode = 1;
        wait_idle();
        or_mode = 2;
        @(negedge clk);
        op = 3'd2; src_a = 32'hA5A5_A5A5; src_b = 32'h0F0F_0F0F; set_flags = 1'b0; in_valid = 1'b1;
        #1;
        check("T4_ready", {63'b0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        op = 3'd4; src_a = 32'h1234_5678; src_b = 32'hFFFF_0000; set_flags = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #2;
            check("T4_hold_valid", {63'b0, out_valid}, 64'd1);
            check("T4_hold_result", {32'b0, result}, 64'h0505_0505);
            check("T4_hold_flags", {60'b0, flags}, 64'b0001);
            check("T4_hold_ready", {63'b0, in_ready}, 64'd0);
        end
        or_mode = 1;
        @(negedge clk);
        op = 3'd3; src_a = 32'hF0F0_F0F0; src_b = 32'h0F0F_0F0F; set_flags = 1'b1;
        #1;
        check("T4_handoff_ready", {63'b0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        #1;
        check("T4_handoff_valid", {63'b0, out_valid}, 64'd1);
        check("T4_handoff_result", {32'b0, result}, 64'hFFFF_FFFF);
        check("T4_handoff_flags", {60'b0, flags}, 64'b1001);
        $display("directed T4: handoff result=%h flags=%b", result, flags);

        // T5: reset in the middle of a multiply.
        wait_idle();
        @(negedge clk);
        op = 3'd5; src_a = 32'h0000_AAAA; src_b = 32'h3; set_flags = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("T5_rst_valid", {63'b0, out_valid}, 64'd0);
        check("T5_rst_flags", {60'b0, flags}, 64'd0);
        check("T5_rst_result", {32'b0, result}, 64'd0);
        check("T5_rst_ready", {63'b0, in_ready}, 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #2;
            if (out_valid) cnt++;
        end
        check("T5_no_stale", 64'(cnt), 64'd0);
        $display("directed T5: stale valid cycles=%0d", cnt);

        // Randomized traffic with random back-pressure and gaps.
        for (int i = 0; i < 250; i++) begin
            or_mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
            case ($urandom_range(0, 4))
                0: ra = 32'h0;
                1: ra = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                3: ra = 32'h7FFF_FFFF;
                default: ra = $urandom;
            endcase
            rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            send_op(3'($urandom_range(0, 7)), ra, rb, 1'($urandom_range(0, 1)));
            $display("rand %0d: op=%0d a=%h b=%h sf=%0d", i, op, ra, rb, set_flags);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // T6: set_flags=0 and reserved opcode leave flags alone.
        run_directed("T6_addcv", 3'd0, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0, 4'b0111, 1);
        run_directed("T6_sub_nf", 3'd1, 32'h3, 32'h3, 1'b0, 32'h0, 4'b0111, 1);
        run_directed("T6_rsvd", 3'd7, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 32'h0, 4'b0111, 1);

        // Build without the multiplier: MUL behaves as reserved.
        @(negedge clk);
        d2_op = 3'd0; d2_src_a = 32'hFFFF_FFFF; d2_src_b = 32'hFFFF_FFFF; d2_set_flags = 1'b1;
        d2_in_valid = 1'b1;
        @(posedge clk);
        #1;
        d2_in_valid = 1'b0;
        #1;
        check("nomul_add_valid", {63'b0, d2_out_valid}, 64'd1);
        check("nomul_add_result", {32'b0, d2_result}, 64'hFFFF_FFFE);
        check("nomul_add_flags", {60'b0, d2_flags}, 64'b1010);
        @(negedge clk);
        d2_op = 3'd5; d2_src_a = 32'h5; d2_src_b = 32'h7; d2_set_flags = 1'b1; d2_in_valid = 1'b1;
        #1;
        check("nomul_mul_ready", {63'b0, d2_in_ready}, 64'd1);
        @(posedge clk);
        #1;
        d2_in_valid = 1'b0;
        #1;
        check("nomul_mul_valid", {63'b0, d2_out_valid}, 64'd1);
        check("nomul_mul_result", {32'b0, d2_result}, 64'd0);
        check("nomul_mul_flags", {60'b0, d2_flags}, 64'b1010);
        $display("directed nomul: MUL result=%h flags=%b", d2_result, d2_flags);

        repeat (3) @(posedge clk);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
